// File: rtl/jk_seq_pkg.sv
// Shared types and constants for the JK sequence driver.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

    // Saturating increment for the mismatch counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/jk_seq_fifo.sv
// Target FIFO: WIDTH x DEPTH, first-word fall-through read, async active-high reset.
module jk_seq_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/jk_seq_driver.sv
// Steps a JK flip-flop bank through queued target states via the JK excitation table.
// Optional mismatch checker (ERR/ERR_CNT) enabled by defining JK_SEQ_CHECK_EN.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     tgt_data,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    input  logic [WIDTH-1:0]     q_fb,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 busy,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t           state;
    state_t           state_nx;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             busy_d;

    assign tgt_ready = ~full;
    assign push      = tgt_valid & ~full;

    jk_seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (tgt_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = ISSUE;
            ISSUE:   state_nx = CHECK;
            CHECK:   state_nx = empty ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // Excitation is computed on the edge that enters ISSUE, from the settled bank state.
    always_comb begin
        pop = 1'b0;
        j_d = '0;
        k_d = '0;
        if (state_nx == ISSUE) begin
            pop = 1'b1;
            j_d = ~q_fb & head;
            k_d = q_fb & ~head;
        end
        // A pop implies ISSUE next, so only a push can make an otherwise idle FIFO non-empty.
        busy_d = (state_nx != IDLE) | ~empty | push;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j    <= '0;
            k    <= '0;
            busy <= 1'b0;
        end else begin
            j    <= j_d;
            k    <= k_d;
            busy <= busy_d;
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic [WIDTH-1:0] t_hold;

    // Compare on the edge leaving CHECK, when the bank has had a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_hold  <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (pop) t_hold <= head;
            if ((state == CHECK) && (q_fb != t_hold)) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_jk_seq_driver.sv
// Self-checking bench for jk_seq_driver with a behavioural JK bank on the feedback path.
module tb_jk_seq_driver;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tgt_data = 4'h0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       err;
    logic [7:0] err_cnt;

    logic [3:0] bank_q;
    logic [3:0] q_force = 4'h0;
    logic       detach = 1'b0;

    int checks = 0;
    int failures = 0;

    jk_seq_driver dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_data  (tgt_data),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank: Q+ = J&~Q | ~K&Q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bank_q <= 4'h0;
        else     bank_q <= (j & ~bank_q) | (~k & bank_q);
    end

    assign q_fb = detach ? q_force : bank_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: target i issues at edge max(accept_i + 1, previous_issue + 2).
    int         edge_n;
    int         acc_edge[$];
    logic [3:0] acc_data[$];
    int         n_issued;
    int         last_issue;
    logic [3:0] last_t;
    logic [3:0] src[$];
    int         src_idx;

    task automatic model_reset();
        edge_n     = 0;
        acc_edge.delete();
        acc_data.delete();
        n_issued   = 0;
        last_issue = -10;
        last_t     = 4'h0;
        src.delete();
        src_idx    = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        tgt_valid = 1'b0;
        detach    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit want);
        int         occ;
        logic [3:0] ej;
        logic [3:0] ek;
        logic [3:0] t;
        tgt_valid = want && (src_idx < src.size());
        tgt_data  = (src_idx < src.size()) ? src[src_idx] : 4'h0;
        @(posedge clk);
        edge_n++;
        ej  = 4'h0;
        ek  = 4'h0;
        occ = acc_edge.size() - n_issued;
        if (n_issued < acc_edge.size() && acc_edge[n_issued] + 1 <= edge_n
            && last_issue + 2 <= edge_n) begin
            t          = acc_data[n_issued];
            ej         = ~last_t & t;
            ek         = last_t & ~t;
            last_t     = t;
            last_issue = edge_n;
            n_issued++;
        end
        if (tgt_valid && occ < D) begin
            acc_edge.push_back(edge_n);
            acc_data.push_back(tgt_data);
            src_idx++;
        end
        occ = acc_edge.size() - n_issued;
        #1;
        chk("model_j", 32'(j), 32'(ej));
        chk("model_k", 32'(k), 32'(ek));
        chk("model_busy", 32'(busy), 32'(occ > 0 || last_issue >= edge_n - 1));
        chk("model_ready", 32'(tgt_ready), 32'(occ < D));
        chk("model_err", 32'(err), 32'(0));
        if (last_issue == edge_n - 1) chk("model_bank_q", 32'(bank_q), 32'(last_t));
    endtask

    typedef struct {
        logic [3:0] t;
        logic [3:0] ej;
        logic [3:0] ek;
    } vec_t;

    vec_t tbl[7];
    logic [3:0] pool[16];
    logic [3:0] swp;
    logic [3:0] mid_t[6];
    bit         saw_full;
    int         exp_cnt;

    initial begin
        // Excitation from the previous row's target (bank starts at 0000).
        tbl[0] = '{4'b1010, 4'b1010, 4'b0000};
        tbl[1] = '{4'b1111, 4'b0101, 4'b0000};
        tbl[2] = '{4'b0101, 4'b0000, 4'b1010};
        tbl[3] = '{4'b0101, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0000, 4'b0000, 4'b0101};
        tbl[5] = '{4'b0110, 4'b0110, 4'b0000};
        tbl[6] = '{4'b1001, 4'b1001, 4'b0110};

        // Reset with hostile inputs.
        rst       = 1'b1;
        detach    = 1'b1;
        q_force   = 4'b1111;
        tgt_valid = 1'b1;
        tgt_data  = 4'b0011;
        tick(); tick(); tick();
        chk("rst_j", 32'(j), 32'(0));
        chk("rst_k", 32'(k), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        chk("rst_ready", 32'(tgt_ready), 32'(1));
        rst       = 1'b0;
        tgt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_j", 32'(j), 32'(0));
            chk("post_rst_busy", 32'(busy), 32'(0));
        end

        // Table-driven single steps.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tgt_valid = 1'b1;
            tgt_data  = tbl[i].t;
            tick();
            tgt_valid = 1'b0;
            chk("tbl_busy_push", 32'(busy), 32'(1));
            chk("tbl_j_idle", 32'(j), 32'(0));
            tick();
            chk("tbl_j", 32'(j), 32'(tbl[i].ej));
            chk("tbl_k", 32'(k), 32'(tbl[i].ek));
            tick();
            chk("tbl_j_hold", 32'(j), 32'(0));
            chk("tbl_k_hold", 32'(k), 32'(0));
            chk("tbl_bank_q", 32'(bank_q), 32'(tbl[i].t));
            tick();
            chk("tbl_busy_done", 32'(busy), 32'(0));
            chk("tbl_err", 32'(err), 32'(0));
        end

        // Checker with the bank detached and Q_FB stuck at 0000.
        do_reset();
        detach  = 1'b1;
        q_force = 4'b0000;
        for (int i = 0; i < 2; i++) begin
`ifdef JK_SEQ_CHECK_EN
            exp_cnt = i + 1;
`else
            exp_cnt = 0;
`endif
            tgt_valid = 1'b1;
            tgt_data  = 4'b0001;
            tick();
            tgt_valid = 1'b0;
            tick();
            chk("chk_j", 32'(j), 32'(4'b0001));
            tick();
            chk("chk_cnt_before", 32'(err_cnt), 32'(exp_cnt - ((exp_cnt > 0) ? 1 : 0)));
            tick();
            chk("chk_err", 32'(err), 32'(exp_cnt > 0));
            chk("chk_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        end
        detach = 1'b0;

        // Mid-operation reset during ISSUE with three targets queued.
        do_reset();
        mid_t = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            tgt_valid = 1'b1;
            tgt_data  = mid_t[i];
            tick();
        end
        tgt_valid = 1'b0;
        chk("mid_j_pre", 32'(j), 32'(4'b1111));
        rst = 1'b1;
        #2;
        chk("mid_j_async", 32'(j), 32'(0));
        chk("mid_k_async", 32'(k), 32'(0));
        chk("mid_busy_async", 32'(busy), 32'(0));
        chk("mid_ready_async", 32'(tgt_ready), 32'(1));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_j_after", 32'(j), 32'(0));
            chk("mid_k_after", 32'(k), 32'(0));
            chk("mid_busy_after", 32'(busy), 32'(0));
        end

        // Randomized stream against the reference model.
        do_reset();
        for (int i = 0; i < 60; i++) src.push_back(4'($urandom_range(0, 15)));
        for (int c = 0; c < 400; c++) step($urandom_range(0, 9) < 6);
        chk("rand_final_q", 32'(bank_q), 32'(src[59]));
        chk("rand_final_busy", 32'(busy), 32'(0));

        // Back-pressure: valid held for 10 distinct targets.
        do_reset();
        for (int i = 0; i < 16; i++) pool[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int r;
            r       = $urandom_range(0, i);
            swp     = pool[i];
            pool[i] = pool[r];
            pool[r] = swp;
        end
        for (int i = 0; i < 10; i++) src.push_back(pool[i]);
        saw_full = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            if (!tgt_ready) saw_full = 1'b1;
        end
        chk("bp_saw_full", 32'(saw_full), 32'(1));
        chk("bp_final_q", 32'(bank_q), 32'(pool[9]));
        chk("bp_final_busy", 32'(busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Drives a bank of WIDTH JK flip-flops so that their outputs step through a queued sequence of target states. Each target is converted to J/K inputs using the JK excitation table (J = ~Q & T, K = Q & ~T), based on the bank's fed-back Q. Between steps the block holds J = K = 0, and it can check the bank's actual state against each target. It sits between a stimulus/control source and the JK flip-flop bank, as the inverse of the flip-flop's characteristic equation.

## Interface
- WIDTH, 4, number of JK flip-flops driven (bits per target)
- DEPTH, 4, target FIFO entries (power of two, >= 2)
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- TGT_DATA  in  WIDTH  next target state for the bank
- TGT_VALID  in  1  TGT_DATA valid
- TGT_READY  out  1  FIFO can accept; = ~full
- Q_FB  in  WIDTH  Q outputs of the driven JK bank
- J  out  WIDTH  registered J inputs to bank
- K  out  WIDTH  registered K inputs to bank
- BUSY  out  1  FIFO non-empty or FSM not IDLE
- ERR  out  1  sticky mismatch flag
- ERR_CNT  out  8  saturating mismatch count

## Operation
- Push on the rising edge where TGT_VALID & TGT_READY. TGT_READY depends only on full, so a full FIFO blocks a push even if a pop happens on the same edge. Pushes while RST is high are ignored.
- FSM states:
  - IDLE (0): J = K = 0. Goes to ISSUE on the next edge when the FIFO is non-empty.
  - ISSUE (1): on entry, pops the head T and registers J = ~Q_FB & T, K = Q_FB & ~T. Don't-cares resolve to 0: hold gives 00, set gives 10, reset gives 01, and 11 is never produced. Always goes to CHECK.
  - CHECK (2): registers J = K = 0. On leaving CHECK, compares Q_FB against the held T. Next state is ISSUE if the FIFO is non-empty, else IDLE.
- Throughput: one target per 2 cycles. The CHECK hold cycle guarantees Q_FB is stable when the next excitation is computed.
- Reset values: J = 0, K = 0, BUSY = 0, ERR = 0, ERR_CNT = 0, FIFO empty (so TGT_READY = 1), state IDLE.
- Reset asserted mid-operation: J/K clear immediately (asynchronously). Queued and in-flight targets are dropped, and no comparison is made.

## Timing
- A target accepted at edge e, with the FSM in IDLE, drives J/K from edge e+1. The bank samples them and updates at e+2; J/K return to 0 at e+2. Q_FB is compared at e+3, and the next ISSUE can also occur at e+3.
- ERR/ERR_CNT update on the comparison edge. ERR_CNT saturates at 255 and is cleared only by RST.
- BUSY falls on the edge that enters IDLE with the FIFO empty.

## Configuration
- Macro JK_SEQ_CHECK_EN.
- Defined: the comparator, ERR, and ERR_CNT are active as described.
- Undefined: the comparator is removed and ERR and ERR_CNT are tied to 0. The CHECK state, its J = K = 0 hold cycle, and all timing are unchanged.

## Structure
- Package jk_seq_pkg:
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, CHECK = 2'd2
  - ERR_CNT_W = 8
  - ERR_CNT_MAX = 8'hFF
- Sub-module jk_seq_fifo: synchronous FIFO (WIDTH × DEPTH, full/empty flags, async reset), instantiated once.
- The FSM, excitation logic, and checker live in the top level.

## Test plan
All scenarios use WIDTH = 4 with a behavioural JK bank (reset Q = 0000) on Q_FB, unless noted.
- Reset: hold RST high with Q_FB = 1111 and TGT_VALID = 1 → J = 0000, K = 0000, BUSY = 0, ERR = 0, TGT_READY = 1, nothing queued after release.
- Single step: push 1010 from Q = 0000 → J = 1010, K = 0000 for exactly one cycle starting one edge after the push; bank Q = 1010; ERR stays 0.
- Sequence: push 1111, 0101, 0101, 0000 → (J, K) sequence is (1111, 0000), (0000, 1010), (0000, 0000), (0000, 0101), each followed by a (0000, 0000) cycle; bank ends at 0000.
- Back-pressure: hold TGT_VALID high for 10 distinct targets → TGT_READY falls when occupancy reaches 4; the bank Q sequence equals push order with no loss or duplication; BUSY falls after the last CHECK.
- Checker: tie Q_FB = 0000 (bank detached) and push 0001 twice → ERR = 1 and ERR_CNT = 1 after the first compare, ERR_CNT = 2 after the second. With JK_SEQ_CHECK_EN undefined, ERR = 0 and ERR_CNT = 0.
- Mid-op reset: pulse RST during ISSUE with 3 targets queued → J/K go to 0 before the next edge, BUSY = 0, and no queued target is issued after release.
